// File: rtl/audio_pkg.sv
// Shared definitions for the audio frame sequencer: sample width and the
// sequencer state encoding.
package audio_pkg;

    localparam int AUDIO_DATA_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_ISSUE_L = 3'd2,
        ST_WAIT_L  = 3'd3,
        ST_ISSUE_R = 3'd4,
        ST_WAIT_R  = 3'd5,
        ST_OUTPUT  = 3'd6
    } audio_seq_state_t;

endpackage

// File: rtl/audio_filter_sequencer.sv
// Captures stereo frames from the CODEC, time-multiplexes one shared FIR filter
// across left then right, and returns the (muted until primed) pair to the CODEC.
module audio_filter_sequencer
    import audio_pkg::*;
#(
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int LOG_N    = 3,
    parameter int FILT_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    output logic              read,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    input  logic              bypass,
    output logic              filt_en,
    output logic              filt_chan,
    output logic [DATA_W-1:0] filt_in,
    input  logic [DATA_W-1:0] filt_out,
    output logic              primed,
    output logic              busy
);

    localparam int                CNT_W     = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
    localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(FILT_LAT - 1);
    localparam logic [CNT_W-1:0]  LAT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAT_ZERO  = CNT_W'(0);
    localparam logic [LOG_N:0]    PRIME_CNT = {1'b1, {LOG_N{1'b0}}};
    localparam logic [LOG_N:0]    FRAME_ONE = (LOG_N+1)'(1);
    localparam logic [DATA_W-1:0] ZERO_SMP  = {DATA_W{1'b0}};

    audio_seq_state_t  state_r, state_s;
    logic [CNT_W-1:0]  lat_cnt_r;
    logic [DATA_W-1:0] left_lat_r, right_lat_r, left_res_r;
    logic [DATA_W-1:0] left_out_r, right_out_r;
    logic              bypass_lat_r;
    logic [LOG_N:0]    frame_cnt_r;
    logic              lat_done_s;
    logic              write_s;
    logic              load_out_s;
    logic              primed_s;

    assign lat_done_s = (lat_cnt_r == LAT_ZERO);
    assign primed_s   = (frame_cnt_r == PRIME_CNT);
    assign primed     = primed_s;
    assign busy       = (state_r != ST_IDLE);
    assign write      = write_s;
    assign left_out   = left_out_r;
    assign right_out  = right_out_r;

    // Next-state decode and per-state strobes to the CODEC and the filter
    always_comb begin
        state_s    = state_r;
        read       = 1'b0;
        filt_en    = 1'b0;
        filt_chan  = 1'b0;
        filt_in    = ZERO_SMP;
        write_s    = 1'b0;
        load_out_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (read_ready) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                read    = 1'b1;
                state_s = ST_ISSUE_L;
            end
            ST_ISSUE_L: begin
                filt_en = 1'b1;
                filt_in = left_lat_r;
                state_s = ST_WAIT_L;
            end
            ST_WAIT_L: begin
                if (lat_done_s) begin
                    state_s = ST_ISSUE_R;
                end else begin
                    state_s = ST_WAIT_L;
                end
            end
            ST_ISSUE_R: begin
                filt_en   = 1'b1;
                filt_chan = 1'b1;
                filt_in   = right_lat_r;
                state_s   = ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (lat_done_s) begin
                    state_s    = ST_OUTPUT;
                    load_out_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_R;
                end
            end
            ST_OUTPUT: begin
                if (write_ready) begin
                    write_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUTPUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and filter-latency down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            lat_cnt_r <= LAT_ZERO;
        end else begin
            state_r <= state_s;
            if (state_r == ST_ISSUE_L || state_r == ST_ISSUE_R) begin
                lat_cnt_r <= LAT_LOAD;
            end else if (!lat_done_s) begin
                lat_cnt_r <= lat_cnt_r - LAT_ONE;
            end
        end
    end

    // Frame capture, filter result capture and output sample registers
    always_ff @(posedge clk) begin
        if (reset) begin
            left_lat_r   <= ZERO_SMP;
            right_lat_r  <= ZERO_SMP;
            bypass_lat_r <= 1'b0;
            left_res_r   <= ZERO_SMP;
            left_out_r   <= ZERO_SMP;
            right_out_r  <= ZERO_SMP;
        end else begin
            if (read) begin
                left_lat_r   <= left_in;
                right_lat_r  <= right_in;
                bypass_lat_r <= bypass;
            end
            if (state_r == ST_WAIT_L && lat_done_s) begin
                left_res_r <= filt_out;
            end
            // Right result is taken straight from the filter on the entry edge
            if (load_out_s) begin
                if (!primed_s) begin
                    left_out_r  <= ZERO_SMP;
                    right_out_r <= ZERO_SMP;
                end else if (bypass_lat_r) begin
                    left_out_r  <= left_lat_r;
                    right_out_r <= right_lat_r;
                end else begin
                    left_out_r  <= left_res_r;
                    right_out_r <= filt_out;
                end
            end
        end
    end

    // Saturating count of written frames; output stays muted until it fills
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= {(LOG_N+1){1'b0}};
        end else if (write_s && !primed_s) begin
            frame_cnt_r <= frame_cnt_r + FRAME_ONE;
        end
    end

endmodule

// File: tb/tb_audio_filter_sequencer.sv
// Self-checking bench: directed vector table, reset/backpressure corner cases and
// randomized frames against a frame-level reference model.
module tb_audio_filter_sequencer;

    localparam int DW = 24;
    localparam int LN = 3;
    localparam int FL = 1;
    localparam int PRIME = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          read_ready, write_ready, bypass;
    logic [DW-1:0] left_in, right_in;
    logic          read, write, filt_en, filt_chan, primed, busy;
    logic [DW-1:0] left_out, right_out, filt_in, filt_out, stub_r;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;
    logic [DW-1:0] prev_l = '0;
    logic [DW-1:0] prev_r = '0;

    always #5 clk = ~clk;

    audio_filter_sequencer #(.DATA_W(DW), .LOG_N(LN), .FILT_LAT(FL)) dut (
        .clk(clk), .reset(reset), .read_ready(read_ready), .left_in(left_in),
        .right_in(right_in), .read(read), .write_ready(write_ready), .write(write),
        .left_out(left_out), .right_out(right_out), .bypass(bypass),
        .filt_en(filt_en), .filt_chan(filt_chan), .filt_in(filt_in),
        .filt_out(filt_out), .primed(primed), .busy(busy)
    );

    // Stub filter: result is input + 1, one cycle after issue
    always_ff @(posedge clk) begin
        if (reset) stub_r <= '0;
        else if (filt_en) stub_r <= filt_in + 24'd1;
    end
    assign filt_out = stub_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One frame starting in IDLE; write_ready held low for 'hold' OUTPUT cycles
    task automatic run_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input logic byp, input int hold,
                             input logic [DW-1:0] el, input logic [DW-1:0] er);
        @(negedge clk);
        read_ready = 1'b1; left_in = l; right_in = r; bypass = byp; write_ready = 1'b0;
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_primed", {31'd0, primed}, {31'd0, model_cnt >= PRIME});
        for (int c = 1; c <= 6 + hold; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                left_in = DW'($urandom); right_in = DW'($urandom); bypass = 1'($urandom);
            end
            write_ready = (c >= 6 + hold);
            #1;
            chk("read", {31'd0, read}, {31'd0, c == 1});
            chk("filt_en", {31'd0, filt_en}, {31'd0, (c == 2) || (c == 4)});
            chk("busy", {31'd0, busy}, 32'd1);
            chk("write", {31'd0, write}, {31'd0, c == 6 + hold});
            if (c == 2) begin
                chk("chan_l", {31'd0, filt_chan}, 32'd0);
                chk("filt_in_l", {8'd0, filt_in}, {8'd0, l});
            end
            if (c == 4) begin
                chk("chan_r", {31'd0, filt_chan}, 32'd1);
                chk("filt_in_r", {8'd0, filt_in}, {8'd0, r});
            end
            chk("left_out", {8'd0, left_out}, {8'd0, (c < 6) ? prev_l : el});
            chk("right_out", {8'd0, right_out}, {8'd0, (c < 6) ? prev_r : er});
        end
        read_ready = 1'b0;
        prev_l = el;
        prev_r = er;
        if (model_cnt < PRIME) model_cnt++;
    endtask

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          byp;
        int            hold;
        logic [DW-1:0] el;
        logic [DW-1:0] er;
        logic          ep;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [DW-1:0] rl, rr, el, er;
        logic rb;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{24'd100, 24'hFFFFFB, 1'b0, 0, 24'd0, 24'd0, (i == 7)};
        tbl[8]  = '{24'd100, 24'hFFFFFB, 1'b0, 0, 24'd101, 24'hFFFFFC, 1'b1};
        tbl[9]  = '{24'hFFFFF0, 24'd7, 1'b1, 0, 24'hFFFFF0, 24'd7, 1'b1};
        tbl[10] = '{24'd3, 24'hFFFC18, 1'b0, 5, 24'd4, 24'hFFFC19, 1'b1};
        tbl[11] = '{24'h7FFFFF, 24'h800000, 1'b1, 2, 24'h7FFFFF, 24'h800000, 1'b1};
        tbl[12] = '{24'h7FFFFF, 24'hFFFFFF, 1'b0, 0, 24'h800000, 24'h000000, 1'b1};

        reset = 1'b1; read_ready = 1'b0; write_ready = 1'b0; bypass = 1'b0;
        left_in = '0; right_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_primed", {31'd0, primed}, 32'd0);
        chk("rst_strobes", {29'd0, read, write, filt_en}, 32'd0);
        chk("rst_chan", {31'd0, filt_chan}, 32'd0);
        chk("rst_outs", {8'd0, left_out | right_out | filt_in}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_frame(tbl[i].l, tbl[i].r, tbl[i].byp, tbl[i].hold, tbl[i].el, tbl[i].er);
            @(posedge clk); #1;
            chk("tbl_primed", {31'd0, primed}, {31'd0, tbl[i].ep});
        end

        // Reset while waiting on the right-channel result
        @(negedge clk);
        read_ready = 1'b1; left_in = 24'd55; right_in = 24'd66; write_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 5) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0; read_ready = 1'b0; #1;
        chk("wr_rst_busy", {31'd0, busy}, 32'd0);
        chk("wr_rst_primed", {31'd0, primed}, 32'd0);
        chk("wr_rst_outs", {8'd0, left_out | right_out}, 32'd0);
        model_cnt = 0; prev_l = '0; prev_r = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            chk("wr_rst_nowrite", {30'd0, write, busy}, 32'd0);
        end
        run_frame(24'd9, 24'd10, 1'b0, 0, 24'd0, 24'd0);

        // Randomized frames against the frame-level model
        for (int i = 0; i < 30; i++) begin
            rl = DW'($urandom);
            rr = DW'($urandom);
            rb = 1'($urandom);
            if (model_cnt < PRIME) begin
                el = '0; er = '0;
            end else if (rb) begin
                el = rl; er = rr;
            end else begin
                el = rl + 24'd1; er = rr + 24'd1;
            end
            run_frame(rl, rr, rb, int'($urandom_range(0, 3)), el, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_filter_sequencer.md
# audio_filter_sequencer

Frame sequencer that sits between the audio CODEC handshake and one shared single-channel FIR averaging datapath. It captures each stereo frame from the CODEC and time-multiplexes the one filter instance across left then right. It returns the filtered pair to the CODEC and mutes output until the filter's delay line holds 2**LOG_N frames. This replaces one filter instance per channel.

## Interface
- DATA_W, 24, sample width (two's complement)
- LOG_N, 3, log2 of filter taps; priming length 2**LOG_N frames
- FILT_LAT, 1, filter result latency in cycles after filt_en (≥1)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- read_ready  in  1  CODEC has an input frame available
- left_in, right_in  in  DATA_W  CODEC input samples
- read  out  1  one-cycle consume pulse to CODEC
- write_ready  in  1  CODEC can accept an output frame
- write  out  1  output frame strobe to CODEC
- left_out, right_out  out  DATA_W  registered output samples
- bypass  in  1  output raw samples instead of filtered ones
- filt_en  out  1  one-cycle issue strobe to shared filter
- filt_chan  out  1  0 = left, 1 = right; valid with filt_en
- filt_in  out  DATA_W  sample to filter; valid with filt_en
- filt_out  in  DATA_W  filter result, valid FILT_LAT cycles after filt_en
- primed  out  1  frame count has reached 2**LOG_N
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, CAPTURE, ISSUE_L, WAIT_L, ISSUE_R, WAIT_R, OUTPUT.
- IDLE → CAPTURE when read_ready. CAPTURE: read=1; latch left_in, right_in and bypass at the end of the cycle.
- ISSUE_L: filt_en=1, filt_chan=0, filt_in=latched left. WAIT_L lasts FILT_LAT cycles; filt_out is captured into the left result at the end of the last WAIT_L cycle. ISSUE_R/WAIT_R do the same with chan=1.
- WAIT_x uses an internal down-counter loaded with FILT_LAT-1.
- OUTPUT: write = (state==OUTPUT) & write_ready, combinational. Go to IDLE on the same edge as write. Hold OUTPUT while write_ready=0.
- read_ready is ignored outside IDLE. No frames are queued here; CODEC-side FIFOs absorb backpressure.
- left_out/right_out are loaded on entry to OUTPUT and held until the next entry.
  - Output value is 0 if !primed.
  - Otherwise it is the raw latched sample if the latched bypass=1, else the filter result.
- The filter is always issued, even when muted or in bypass, so its delay line keeps filling.
- frame_cnt is a saturating counter of width LOG_N+1. It increments on each write. primed = (frame_cnt == 2**LOG_N).
- No arithmetic on samples; all values pass through bit-exact.

## Timing
- Reset values: state IDLE; read, write, filt_en, busy, primed = 0; left_out, right_out, filt_in = 0; filt_chan = 0; frame_cnt = 0.
- read_ready high in IDLE at cycle t: read in t+1, filt_en(L) in t+2, filt_en(R) in t+3+FILT_LAT, OUTPUT entered at t+4+2·FILT_LAT.
- Earliest write is at t+4+2·FILT_LAT. With FILT_LAT=1, that is t+6.
- Frame throughput is at most one per 5+2·FILT_LAT cycles.
- Reset asserted in any state: all of the above reset values apply at the next edge. The in-flight frame is discarded with no write. The filter shares the reset.
- Saturation: frame_cnt stays at 2**LOG_N; primed stays 1 until reset.

## Structure
- Shared package audio_pkg holds DATA_W and the state enum typedef audio_seq_state_t.
- No sub-module. The filter datapath is instantiated beside this block, not inside it. The latency counter and frame counter are inline.

## Test plan
Bench uses LOG_N=3, FILT_LAT=1, and a stub filter with filt_out = filt_in + 1 one cycle later.
- Reset for 2 cycles → all outputs 0, busy=0, primed=0.
- read_ready=1 at cycle 0, write_ready=1 → read@1, filt_en/chan0@2, filt_en/chan1@4, write@6, exactly one pulse each.
- 8 frames with left_in=100, right_in=-5 → left_out=right_out=0 on writes 1–8, primed=1 after the 8th write; 9th frame → left_out=101, right_out=-4.
- Primed, bypass=1, left_in=-16 → left_out=-16; filt_en still pulses twice.
- write_ready=0 for 5 cycles in OUTPUT with read_ready=1 → no read, outputs stable, write on the cycle write_ready rises, then the next CAPTURE.
- reset in WAIT_R → IDLE next cycle, frame_cnt=0, no write, outputs 0.
